cache_refill: RTL and testbench
===============================

# cache_refill

Read-side controller for `cache_ro`. Accepts word read requests from a ray-tracing datapath client, probes the cache, and on a miss fetches the word from external memory over an Avalon-MM pipelined read master. It then writes the word into the cache and returns it to the client. It is the initiator that drives the cache's `en/wrt/i_addr/i_data` ports and consumes `o_data/o_success`.

## Interface
- `SIZE_BLOCK`, 32: data word / cache block width in bits
- `BIT_TOTAL`, 24: word address width

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1: client read request
- `req_ready` out 1: controller can accept a request
- `req_addr` in BIT_TOTAL: word address, sampled on accept
- `rsp_valid` out 1: one-cycle pulse, response data valid
- `rsp_data` out SIZE_BLOCK: read data
- `rsp_hit` out 1: qualifies `rsp_valid`; 1 = cache hit, 0 = refilled
- `c_en`, `c_wrt` out 1: cache enable / write select
- `c_addr` out BIT_TOTAL: cache address
- `c_data` out SIZE_BLOCK: cache write data
- `c_rdata` in SIZE_BLOCK: cache `o_data`, valid the cycle after a read strobe
- `c_success` in 1: cache `o_success`, hit flag, same timing as `c_rdata`
- `m_read` out 1: memory read request
- `m_addr` out BIT_TOTAL: memory word address
- `m_waitrequest` in 1: memory stall; request accepted when `m_read & !m_waitrequest`
- `m_rdata` in SIZE_BLOCK: memory read data
- `m_rdatavalid` in 1: memory data valid, at earliest the cycle after acceptance

## Operation
- FSM states and transitions:
  - IDLE: `req_ready`=1. If `req_valid`, latch `req_addr` into `addr_q` and go to PROBE.
  - PROBE: `c_en`=1, `c_wrt`=0, `c_addr`=`addr_q`. Go to CHECK.
  - CHECK: sample `c_success`/`c_rdata`. On hit, latch data, set hit flag, go to RESP. On miss, go to MEM_REQ.
  - MEM_REQ: `m_read`=1, `m_addr`=`addr_q`, held stable until `!m_waitrequest`, then go to MEM_WAIT.
  - MEM_WAIT: wait for `m_rdatavalid`. Latch `m_rdata`, clear hit flag, go to FILL.
  - FILL: `c_en`=1, `c_wrt`=1, `c_addr`=`addr_q`, `c_data`=latched data. Go to RESP.
  - RESP: `rsp_valid`=1 with `rsp_data` and `rsp_hit`. Go to IDLE.
- Exactly one outstanding memory read at a time.
- `m_rdatavalid` outside MEM_WAIT is ignored. This covers stray responses after reset.
- `c_en` is low in every state except PROBE and FILL. `c_data` is don't-care when `c_wrt`=0 but is driven from the data register (no X).
- The client has no backpressure on responses. The client must accept `rsp_valid` whenever it is asserted.

## Timing
- Reset values: `req_ready`=0 while `rst` is high, then 1 in IDLE. `rsp_valid`=0, `rsp_hit`=0, `rsp_data`=0, `c_en`=0, `c_wrt`=0, `c_addr`=0, `c_data`=0, `m_read`=0, `m_addr`=0. State is IDLE.
- The FSM state and all data/address registers reset asynchronously. FSM outputs are decoded from the state register.
- Hit latency: request accepted at edge N; PROBE during N..N+1; `rsp_valid` high during cycle N+3.
- Miss latency: with zero wait states and `m_rdatavalid` the cycle after acceptance, `rsp_valid` is high during cycle N+6. Each `m_waitrequest` cycle adds 1, and each extra data-latency cycle adds 1.
- Back-to-back requests: the next request is accepted at earliest the cycle after RESP, giving a minimum hit spacing of 4 cycles.
- Reset mid-operation (any state): outputs return to reset values immediately and the FSM goes to IDLE.
  - An in-flight memory response is discarded.
  - A cache line may be left unfilled but is never partially written.

## Configuration
- `CACHE_REFILL_STATS_EN` defined: adds outputs `o_hit_cnt` and `o_miss_cnt`, each 32 bits.
  - Both reset to 0.
  - Each increments in CHECK on hit or miss respectively, saturating at 32'hFFFF_FFFF.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Test plan
All scenarios use a memory model that returns mem[a] = 32'h00A0_0000 | a.
- Cold read: addr 'd3 → miss; `m_addr`='d3; one FILL with `c_data`=32'h00A0_0003; `rsp_valid` with `rsp_data`=32'h00A0_0003, `rsp_hit`=0, at N+6 with zero wait states.
- Warm read: repeat addr 'd3 → no `m_read`; `rsp_data`=32'h00A0_0003, `rsp_hit`=1 at N+3.
- Conflict (BIT_INDEX=5 cache): read 'd0, 'd32, 'd0.
  - Read 'd0 → miss.
  - Read 'd32 → miss.
  - Read 'd0 → miss again, `rsp_data`=32'h00A0_0000.
- Stall: `m_waitrequest` high for 3 cycles and data latency 2 on addr 'd64.
  - `m_read`/`m_addr`='d64 held stable for 4 cycles.
  - Response at N+10 with `rsp_data`=32'h00A0_0040.
- Reset in MEM_WAIT: assert `rst` for 1 cycle, then deliver a stray `m_rdatavalid`.
  - No FILL and no `rsp_valid`.
  - A following read of the same address misses.
- Busy/stats: hold `req_valid` during a miss → `req_ready`=0 until IDLE. With `CACHE_REFILL_STATS_EN`, after the first four scenarios `o_hit_cnt`=1 and `o_miss_cnt`=5.

Source files
------------

// File: rtl/cache_refill.sv
// cache_refill: read-miss refill controller between a client, cache_ro and an Avalon-MM read master.
// Define CACHE_REFILL_STATS_EN to add saturating hit/miss counters.
module cache_refill #(
   parameter int SIZE_BLOCK = 32,
   parameter int BIT_TOTAL  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [BIT_TOTAL-1:0]  req_addr,
   output logic                  rsp_valid,
   output logic [SIZE_BLOCK-1:0] rsp_data,
   output logic                  rsp_hit,
   output logic                  c_en,
   output logic                  c_wrt,
   output logic [BIT_TOTAL-1:0]  c_addr,
   output logic [SIZE_BLOCK-1:0] c_data,
   input  logic [SIZE_BLOCK-1:0] c_rdata,
   input  logic                  c_success,
   output logic                  m_read,
   output logic [BIT_TOTAL-1:0]  m_addr,
   input  logic                  m_waitrequest,
   input  logic [SIZE_BLOCK-1:0] m_rdata,
   input  logic                  m_rdatavalid
`ifdef CACHE_REFILL_STATS_EN
   ,
   output logic [31:0]           o_hit_cnt,
   output logic [31:0]           o_miss_cnt
`endif
);
   typedef enum logic [2:0] {IDLE, PROBE, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP} state_t;
   state_t                state;
   logic [BIT_TOTAL-1:0]  addr_q;
   logic [SIZE_BLOCK-1:0] data_q;
   logic                  hit_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         addr_q <= '0;
         data_q <= '0;
         hit_q  <= 1'b0;
      end else
         case (state)
            IDLE:
               if (req_valid) begin
                  addr_q <= req_addr;
                  state  <= PROBE;
               end
            PROBE: state <= CHECK;
            CHECK:
               if (c_success) begin
                  data_q <= c_rdata;
                  hit_q  <= 1'b1;
                  state  <= RESP;
               end else
                  state <= MEM_REQ;
            MEM_REQ: state <= m_waitrequest ? MEM_REQ : MEM_WAIT;
            MEM_WAIT:
               if (m_rdatavalid) begin
                  data_q <= m_rdata;
                  hit_q  <= 1'b0;
                  state  <= FILL;
               end
            FILL:    state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
   // ready is masked by rst so the client never sees a handshake during reset
   assign req_ready = state == IDLE && !rst;
   assign rsp_valid = state == RESP;
   assign rsp_data  = data_q;
   assign rsp_hit   = hit_q;
   assign c_en      = state == PROBE || state == FILL;
   assign c_wrt     = state == FILL;
   assign c_addr    = addr_q;
   assign c_data    = data_q;
   assign m_read    = state == MEM_REQ;
   assign m_addr    = addr_q;
`ifdef CACHE_REFILL_STATS_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
      end else if (state == CHECK) begin
         o_hit_cnt  <= (c_success && ~&o_hit_cnt) ? o_hit_cnt + 32'd1 : o_hit_cnt;
         o_miss_cnt <= (!c_success && ~&o_miss_cnt) ? o_miss_cnt + 32'd1 : o_miss_cnt;
      end
`endif
endmodule

// File: tb/tb_cache_refill.sv
// tb_cache_refill: directed bench with a direct-mapped cache model (32 lines) and an Avalon memory model.
// Memory returns 32'h00A0_0000 | addr with programmable wait states and data latency.
module tb_cache_refill;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [23:0] req_addr = '0;
   logic        rsp_valid, rsp_hit;
   logic [31:0] rsp_data;
   logic        c_en, c_wrt, c_success = 1'b0;
   logic [23:0] c_addr, m_addr;
   logic [31:0] c_data, c_rdata = '0, m_rdata;
   logic        m_read, m_waitrequest, m_rdatavalid;
`ifdef CACHE_REFILL_STATS_EN
   logic [31:0] o_hit_cnt, o_miss_cnt;
`endif
   int vectors = 0, miscompares = 0;
   int fills = 0, mreads = 0, mbad = 0, rsps = 0, busy_bad = 0;
   logic [31:0] fill_data = '0;
   logic [23:0] exp_a = '0;
   int ws = 0, lat_cfg = 1, wcnt = 0, dcnt = 0;
   logic [23:0] pa = '0;
   logic        cv [32];
   logic [18:0] ct [32];
   logic [31:0] cd [32];

   cache_refill dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
      .c_en(c_en), .c_wrt(c_wrt), .c_addr(c_addr), .c_data(c_data),
      .c_rdata(c_rdata), .c_success(c_success),
      .m_read(m_read), .m_addr(m_addr), .m_waitrequest(m_waitrequest),
      .m_rdata(m_rdata), .m_rdatavalid(m_rdatavalid)
`ifdef CACHE_REFILL_STATS_EN
      , .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (c_en && c_wrt) begin
         cv[c_addr[4:0]] <= 1'b1;
         ct[c_addr[4:0]] <= c_addr[23:5];
         cd[c_addr[4:0]] <= c_data;
      end else if (c_en) begin
         c_rdata   <= cd[c_addr[4:0]];
         c_success <= cv[c_addr[4:0]] && ct[c_addr[4:0]] == c_addr[23:5];
      end

   assign m_waitrequest = m_read && (wcnt < ws);
   assign m_rdatavalid  = dcnt == 1;
   assign m_rdata       = 32'h00A0_0000 | {8'h00, pa};
   always @(posedge clk) begin
      if (m_read) wcnt <= m_waitrequest ? wcnt + 1 : 0;
      if (m_read && !m_waitrequest) begin
         dcnt <= lat_cfg;
         pa   <= m_addr;
      end else if (dcnt > 0)
         dcnt <= dcnt - 1;
   end

   always @(negedge clk) begin
      if (c_en && c_wrt) begin
         fills++;
         fill_data = c_data;
      end
      if (m_read) begin
         mreads++;
         if (m_addr !== exp_a) mbad++;
      end
      if (rsp_valid) rsps++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [23:0] a, input bit hold, output int lat);
      fills = 0; mreads = 0; mbad = 0; busy_bad = 0; exp_a = a; lat = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk);
      #1 if (!hold) req_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = i;
            break;
         end
         if (hold && req_ready) busy_bad++;
      end
      req_valid = 1'b0;
   endtask

   initial begin
      int lat, f0, r0;
      for (int i = 0; i < 32; i++) begin
         cv[i] = 1'b0; ct[i] = '0; cd[i] = '0;
      end
      #12;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_hit", rsp_hit, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_c_en_wrt", {c_en, c_wrt}, 0);
      chk("rst_c_addr_data", {c_addr, c_data}, 0);
      chk("rst_m_read_addr", {m_read, m_addr}, 0);
      @(negedge clk); rst = 1'b0;
      #1 chk("idle_req_ready", req_ready, 1);
      // cold read
      req(24'd3, 1'b0, lat);
      chk("cold_lat", lat, 6);
      chk("cold_data", rsp_data, 32'h00A0_0003);
      chk("cold_hit", rsp_hit, 0);
      chk("cold_fills", fills, 1);
      chk("cold_fill_data", fill_data, 32'h00A0_0003);
      chk("cold_mreads", mreads, 1);
      chk("cold_maddr", mbad, 0);
      // warm read
      req(24'd3, 1'b0, lat);
      chk("warm_lat", lat, 3);
      chk("warm_data", rsp_data, 32'h00A0_0003);
      chk("warm_hit", rsp_hit, 1);
      chk("warm_mreads", mreads, 0);
      chk("warm_fills", fills, 0);
      // conflict on index 0
      req(24'd0, 1'b0, lat);
      chk("conf0_hit", rsp_hit, 0);
      chk("conf0_data", rsp_data, 32'h00A0_0000);
      req(24'd32, 1'b0, lat);
      chk("conf32_hit", rsp_hit, 0);
      chk("conf32_data", rsp_data, 32'h00A0_0020);
      req(24'd0, 1'b0, lat);
      chk("conf0b_lat", lat, 6);
      chk("conf0b_hit", rsp_hit, 0);
      chk("conf0b_data", rsp_data, 32'h00A0_0000);
      // stall: 3 wait states, data latency 2
      ws = 3; lat_cfg = 2;
      req(24'd64, 1'b0, lat);
      chk("stall_lat", lat, 10);
      chk("stall_mreads", mreads, 4);
      chk("stall_maddr", mbad, 0);
      chk("stall_data", rsp_data, 32'h00A0_0040);
      chk("stall_hit", rsp_hit, 0);
      ws = 0; lat_cfg = 6;
`ifdef CACHE_REFILL_STATS_EN
      chk("stats_hit", o_hit_cnt, 1);
      chk("stats_miss", o_miss_cnt, 5);
`endif
      // reset while waiting for memory data
      fills = 0; mreads = 0; mbad = 0; exp_a = 24'd100;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 24'd100;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      f0 = fills; r0 = rsps;
      #1;
      chk("mrst_req_ready", req_ready, 0);
      chk("mrst_outs", {rsp_valid, c_en, c_wrt, m_read}, 0);
      chk("mrst_addr", {m_addr, c_addr}, 0);
      chk("mrst_rsp_data", rsp_data, 0);
`ifdef CACHE_REFILL_STATS_EN
      chk("mrst_stats", {o_hit_cnt, o_miss_cnt}, 0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mrst_no_fill", fills - f0, 0);
      chk("mrst_no_rsp", rsps - r0, 0);
      chk("mrst_idle_ready", req_ready, 1);
      // re-read after reset, holding req_valid through the miss
      lat_cfg = 1;
      req(24'd100, 1'b1, lat);
      chk("after_rst_lat", lat, 6);
      chk("after_rst_hit", rsp_hit, 0);
      chk("after_rst_data", rsp_data, 32'h00A0_0064);
      chk("busy_ready_low", busy_bad, 0);
      chk("busy_ready_resp", req_ready, 0);
      @(negedge clk);
      chk("busy_no_reaccept", {req_ready, rsp_valid}, 2'b10);
      @(negedge clk);
      chk("busy_idle_stays", req_ready, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
